// File: rtl/poly_horner_eval.sv
// poly_horner_eval: evaluates r = a_D*x^D + ... + a_1*x + a_0 with Horner's
// method on one shared multiply/add datapath. Values are entered one per
// go press/release: a_D first, then down to a_0, then x.
//
// Ports:
//   clk          clock
//   resetn       synchronous, active-low reset
//   go           level entry strobe (active-high)
//   data_in      value being entered (WIDTH bits)
//   data_result  registered result of the last evaluation
//   overflow     registered; set if any intermediate of the last evaluation
//                exceeded 2^WIDTH-1
//   done         one-cycle pulse when data_result/overflow update
//   busy         high while evaluating (multiply/add steps)
//   load_ptr     index of the next value expected: 0=a_D ... D=a_0, D+1=x
module poly_horner_eval #(
  parameter int WIDTH    = 8,
  parameter int DEGREE   = 2,
  parameter int SATURATE = 0
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        go,
  input  logic [WIDTH-1:0]            data_in,
  output logic [WIDTH-1:0]            data_result,
  output logic                        overflow,
  output logic                        done,
  output logic                        busy,
  output logic [$clog2(DEGREE+2)-1:0] load_ptr
);

  localparam int               PW       = $clog2(DEGREE+2);
  localparam logic [PW-1:0]    PTR_X    = PW'(DEGREE+1);
  localparam logic [PW-1:0]    K_TOP    = PW'(DEGREE-1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_LOAD      = 3'd0,
    S_LOAD_WAIT = 3'd1,
    S_MUL       = 3'd2,
    S_ADD       = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] coef_q [0:DEGREE];
  logic [WIDTH-1:0] coef_d [0:DEGREE];
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] data_result_q, data_result_d;
  logic             overflow_q, overflow_d;
  logic             ov_q, ov_d;
  logic [PW-1:0]    load_ptr_q, load_ptr_d;
  logic [PW-1:0]    k_q, k_d;

  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH-1:0]   coef_sel_s;
  logic [WIDTH-1:0]   mul_val_s, add_val_s;
  logic               mul_ovf_s, add_ovf_s;

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= S_LOAD;
      x_q           <= '0;
      acc_q         <= '0;
      data_result_q <= '0;
      overflow_q    <= 1'b0;
      ov_q          <= 1'b0;
      load_ptr_q    <= '0;
      k_q           <= '0;
      for (int i = 0; i <= DEGREE; i++) coef_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      acc_q         <= acc_d;
      data_result_q <= data_result_d;
      overflow_q    <= overflow_d;
      ov_q          <= ov_d;
      load_ptr_q    <= load_ptr_d;
      k_q           <= k_d;
      for (int i = 0; i <= DEGREE; i++) coef_q[i] <= coef_d[i];
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD: begin
        if (go) state_d = S_LOAD_WAIT;
        else    state_d = S_LOAD;
      end
      // Holding go keeps us here, so a long press is still a single entry
      S_LOAD_WAIT: begin
        if (go)                       state_d = S_LOAD_WAIT;
        else if (load_ptr_q == PTR_X) state_d = S_MUL;
        else                          state_d = S_LOAD;
      end
      S_MUL: state_d = S_ADD;
      S_ADD: begin
        if (k_q == '0) state_d = S_DONE;
        else           state_d = S_MUL;
      end
      S_DONE:  state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  // Shared multiply/add arithmetic with overflow detection and wrap/clamp
  always_comb begin
    coef_sel_s = '0;
    for (int i = 0; i <= DEGREE; i++) begin
      coef_sel_s = (k_q == PW'(i)) ? coef_q[i] : coef_sel_s;
    end
    prod_s    = {{WIDTH{1'b0}}, acc_q} * {{WIDTH{1'b0}}, x_q};
    mul_ovf_s = |prod_s[2*WIDTH-1:WIDTH];
    mul_val_s = (mul_ovf_s && (SATURATE != 0)) ? ALL_ONES : prod_s[WIDTH-1:0];
    sum_s     = {1'b0, acc_q} + {1'b0, coef_sel_s};
    add_ovf_s = sum_s[WIDTH];
    add_val_s = (add_ovf_s && (SATURATE != 0)) ? ALL_ONES : sum_s[WIDTH-1:0];
  end

  // Register next-values: value capture, Horner steps, result latch
  always_comb begin
    x_d           = x_q;
    acc_d         = acc_q;
    data_result_d = data_result_q;
    overflow_d    = overflow_q;
    ov_d          = ov_q;
    load_ptr_d    = load_ptr_q;
    k_d           = k_q;
    for (int i = 0; i <= DEGREE; i++) coef_d[i] = coef_q[i];
    case (state_q)
      S_LOAD: begin
        if (go) begin
          // Slot D+1 is x; slot p holds coefficient a_(D-p)
          if (load_ptr_q == PTR_X) begin
            x_d = data_in;
          end else begin
            for (int i = 0; i <= DEGREE; i++) begin
              if (load_ptr_q == PW'(DEGREE - i)) coef_d[i] = data_in;
              else                               coef_d[i] = coef_q[i];
            end
          end
        end else begin
          x_d = x_q;
        end
      end
      S_LOAD_WAIT: begin
        if (!go) begin
          if (load_ptr_q == PTR_X) begin
            acc_d = coef_q[DEGREE];
            ov_d  = 1'b0;
            k_d   = K_TOP;
          end else begin
            load_ptr_d = load_ptr_q + PW'(1);
          end
        end else begin
          load_ptr_d = load_ptr_q;
        end
      end
      S_MUL: begin
        acc_d = mul_val_s;
        ov_d  = ov_q | mul_ovf_s;
      end
      S_ADD: begin
        acc_d = add_val_s;
        ov_d  = ov_q | add_ovf_s;
        if (k_q == '0) begin
          data_result_d = add_val_s;
          overflow_d    = ov_q | add_ovf_s;
        end else begin
          k_d = k_q - PW'(1);
        end
      end
      S_DONE: load_ptr_d = '0;
      default: begin
        acc_d = acc_q;
      end
    endcase
  end

  // Moore status outputs decoded from the state register
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_MUL:   busy = 1'b1;
      S_ADD:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  assign data_result = data_result_q;
  assign overflow    = overflow_q;
  assign load_ptr    = load_ptr_q;

endmodule
